// File: rtl/dcs_rx_decoder_if.sv
// -----------------------------------------------------------------------------
// dcs_rx_decoder_if
// Handshake and data bundle between the demodulator frame buffer, the
// dcs_rx_decoder and the downstream CRC-16 checker / link layer.
//
// Signals:
//   in_valid   producer -> decoder  frame_in carries a frame
//   in_ready   decoder  -> producer decoder can accept a frame
//   frame_in   producer -> decoder  96-bit interleaved codeword
//   out_valid  decoder  -> consumer result valid
//   out_ready  consumer -> decoder  consumer takes the result
//   data_out   decoder  -> consumer 48-bit decoded word, b_0 at bit 47
//   err_cnt    decoder  -> consumer parity-mismatch count of the frame
//   frame_err  decoder  -> consumer err_cnt above threshold
//   crc_ok     decoder  -> consumer CRC-16 match (0 unless RX_CRC_CHECK_EN)
//
// Modports: master = frame source / result sink side, slave = decoder side.
// -----------------------------------------------------------------------------
interface dcs_rx_decoder_if #(
   parameter int ERR_CNT_W = 6
);
   logic                 in_valid;
   logic                 in_ready;
   logic [95:0]          frame_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [47:0]          data_out;
   logic [ERR_CNT_W-1:0] err_cnt;
   logic                 frame_err;
   logic                 crc_ok;

   modport master (
      output in_valid, frame_in, out_ready,
      input  in_ready, out_valid, data_out, err_cnt, frame_err, crc_ok
   );

   modport slave (
      input  in_valid, frame_in, out_ready,
      output in_ready, out_valid, data_out, err_cnt, frame_err, crc_ok
   );
endinterface

// File: rtl/dcs_rx_decoder.sv
// -----------------------------------------------------------------------------
// dcs_rx_decoder
// Receive-side DCS FEC decoder. Accepts one 96-bit interleaved frame,
// deinterleaves it, then decodes the 48 rate-1/2 symbol pairs serially, one
// pair per clock. Each pair yields one data bit and one parity consistency
// check; mismatches are counted (saturating) in err_cnt.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any frame in flight
//   s_bus  dcs_rx_decoder_if.slave (in_valid/in_ready/frame_in,
//          out_valid/out_ready/data_out/err_cnt/frame_err/crc_ok)
//
// Parameters:
//   ERR_CNT_W   width of err_cnt, saturates at 2^ERR_CNT_W-1
//   ERR_THRESH  frame_err = err_cnt > ERR_THRESH
//
// Optional feature macro: RX_CRC_CHECK_EN
//   Defined   : serial CRC-16 (x^16+x^15+x^2+1, init FFFF) over b_0..b_31,
//               crc_ok in DONE when it equals {b_32..b_47}.
//   Undefined : no CRC logic, crc_ok tied to 0.
//
// Timing: acceptance edge, 48 decode edges, out_valid high afterwards until
// out_valid && out_ready. One frame every 50 clocks at best.
// -----------------------------------------------------------------------------
module dcs_rx_decoder #(
   parameter int ERR_CNT_W  = 6,
   parameter int ERR_THRESH = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   dcs_rx_decoder_if.slave s_bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;
   localparam logic [5:0]           LAST_IDX = 6'd47;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [95:0]          r_cw;       // codeword, current pair always in [95:94]
   logic [47:0]          r_data;     // decoded bits shifted in at bit 0
   logic [2:0]           r_hist;     // [0]=b_n-1, [1]=b_n-2, [2]=b_n-3
   logic [5:0]           r_idx;      // pair index n
   logic [ERR_CNT_W-1:0] r_err;

   logic [95:0]          w_cw;
   logic                 w_accept;
   logic                 w_decoding;
   logic                 w_last;
   logic                 w_p1;
   logic                 w_p0;
   logic                 w_bit;
   logic                 w_mismatch;
   logic                 w_in_ready;
   logic                 w_out_valid;

   // ---------------------------------------------------------------------------
   // Deinterleave: group g = frame_in[95-24g -: 24], codeword byte k =
   // cw[95-8k -: 8]; byte k bits [2g+1:2g] come from group g bits [2k+1:2k].
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: default assignment first so no path through the block leaves the
      // variable unassigned, which would otherwise infer a latch.
      w_cw = '0;
      for (int g = 0; g < 4; g++) begin
         for (int k = 0; k < 12; k++) begin
            w_cw[88 - 8*k + 2*g +: 2] = s_bus.frame_in[72 - 24*g + 2*k +: 2];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (s_bus.in_valid) begin
               w_state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_out_valid = 1'b1;
            if (s_bus.out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_accept   = (r_state == ST_IDLE) && s_bus.in_valid;
   assign w_decoding = (r_state == ST_DECODE);
   assign w_last     = (r_idx == LAST_IDX);

   // ---------------------------------------------------------------------------
   // Pair decode. The encoder gives P1 = b_n^b_n-2^b_n-3 and
   // P0^P1 = b_n-1, so the data bit is recovered from P1 and history, and
   // P0^P1 is cross-checked against the previous decoded bit.
   // ---------------------------------------------------------------------------
   assign w_p1       = r_cw[95];
   assign w_p0       = r_cw[94];
   assign w_bit      = w_p1 ^ r_hist[1] ^ r_hist[2];
   assign w_mismatch = (w_p0 ^ w_p1) != r_hist[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cw   <= '0;
         r_data <= '0;
         r_hist <= '0;
         r_idx  <= '0;
         r_err  <= '0;
      end else if (w_accept) begin
         r_cw   <= w_cw;
         r_hist <= '0;
         r_idx  <= '0;
         r_err  <= '0;
      end else if (w_decoding) begin
         r_cw   <= {r_cw[93:0], 2'b00};
         r_data <= {r_data[46:0], w_bit};
         r_hist <= {r_hist[1:0], w_bit};
         r_idx  <= r_idx + 6'd1;
         if (w_mismatch && (r_err != ERR_MAX)) begin
            r_err <= r_err + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Optional CRC-16 over b_0..b_31, compared with b_32..b_47 in DONE.
   // ---------------------------------------------------------------------------
`ifdef RX_CRC_CHECK_EN
   logic [15:0] r_crc;
   logic        w_fb;

   assign w_fb = w_bit ^ r_crc[15];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_crc <= 16'hFFFF;
      end else if (w_accept) begin
         r_crc <= 16'hFFFF;
      end else if (w_decoding && (r_idx < 6'd32)) begin
         r_crc <= {r_crc[14] ^ w_fb, r_crc[13:2], r_crc[1] ^ w_fb, r_crc[0], w_fb};
      end
   end

   assign s_bus.crc_ok = (r_state == ST_DONE) && (r_crc == r_data[15:0]);
`else
   assign s_bus.crc_ok = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign s_bus.in_ready  = w_in_ready;
   assign s_bus.out_valid = w_out_valid;
   assign s_bus.data_out  = r_data;
   assign s_bus.err_cnt   = r_err;
   assign s_bus.frame_err = (int'(r_err) > ERR_THRESH);

endmodule

// File: tb/tb_dcs_rx_decoder.sv
// -----------------------------------------------------------------------------
// tb_dcs_rx_decoder
// Self-checking bench for dcs_rx_decoder: a table of fixed frames, hand-written
// multi-cycle sequences (ready pre-asserted, backpressure, mid-frame reset,
// CRC payload) and randomized frames compared with a bit-level reference model.
// -----------------------------------------------------------------------------
module tb_dcs_rx_decoder;

   localparam int ERR_CNT_W  = 6;
   localparam int ERR_THRESH = 0;
   localparam int ERR_MAX    = (1 << ERR_CNT_W) - 1;
`ifdef RX_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   typedef struct {
      logic [95:0]          frame;
      logic [47:0]          exp_data;
      logic [ERR_CNT_W-1:0] exp_err;
      logic                 exp_ferr;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   dcs_rx_decoder_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

   dcs_rx_decoder #(
      .ERR_CNT_W  (ERR_CNT_W),
      .ERR_THRESH (ERR_THRESH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   function automatic logic [95:0] deinterleave(input logic [95:0] fr);
      logic [23:0] grp [4];
      logic [7:0]  byt [12];
      logic [95:0] cw;
      for (int g = 0; g < 4; g++) grp[g] = fr[95 - 24*g -: 24];
      for (int k = 0; k < 12; k++) begin
         byt[k] = '0;
         for (int g = 0; g < 4; g++) byt[k][2*g +: 2] = grp[g][2*k +: 2];
      end
      cw = '0;
      for (int k = 0; k < 12; k++) cw[95 - 8*k -: 8] = byt[k];
      return cw;
   endfunction

   function automatic logic [95:0] interleave(input logic [95:0] cw);
      logic [23:0] grp [4];
      logic [7:0]  byt [12];
      logic [95:0] fr;
      for (int k = 0; k < 12; k++) byt[k] = cw[95 - 8*k -: 8];
      for (int g = 0; g < 4; g++) begin
         grp[g] = '0;
         for (int k = 0; k < 12; k++) grp[g][2*k +: 2] = byt[k][2*g +: 2];
      end
      fr = '0;
      for (int g = 0; g < 4; g++) fr[95 - 24*g -: 24] = grp[g];
      return fr;
   endfunction

   // Codeword from data: bits[i+3] holds b_i so b_-1..b_-3 read as 0.
   function automatic logic [95:0] encode_cw(input logic [47:0] data);
      bit          bits [51];
      logic [95:0] cw;
      for (int i = 0; i < 51; i++) bits[i] = 1'b0;
      for (int n = 0; n < 48; n++) bits[n+3] = data[47-n];
      cw = '0;
      for (int n = 0; n < 48; n++) begin
         cw[95 - 2*n] = bits[n+3] ^ bits[n+1] ^ bits[n];
         cw[94 - 2*n] = bits[n+3] ^ bits[n+2] ^ bits[n+1] ^ bits[n];
      end
      return cw;
   endfunction

   function automatic logic [95:0] encode(input logic [47:0] data);
      return interleave(encode_cw(data));
   endfunction

   task automatic model_decode(input logic [95:0] fr, output logic [47:0] data,
                               output logic [ERR_CNT_W-1:0] err);
      bit          bits [51];
      logic [95:0] cw;
      int          errs;
      bit          p0, p1;
      cw   = deinterleave(fr);
      errs = 0;
      for (int i = 0; i < 51; i++) bits[i] = 1'b0;
      for (int n = 0; n < 48; n++) begin
         p1        = cw[95 - 2*n];
         p0        = cw[94 - 2*n];
         bits[n+3] = p1 ^ bits[n+1] ^ bits[n];
         if ((p0 ^ p1) != bits[n+2]) errs++;
         data[47-n] = bits[n+3];
      end
      if (errs > ERR_MAX) errs = ERR_MAX;
      err = ERR_CNT_W'(errs);
   endtask

   function automatic logic [15:0] crc16(input logic [31:0] payload);
      logic [15:0] r;
      logic        fb;
      r = 16'hFFFF;
      for (int i = 0; i < 32; i++) begin
         fb   = payload[31-i] ^ r[15];
         r    = {r[14:0], 1'b0};
         r[0] = fb;
         r[2] = r[2] ^ fb;
         r[15] = r[15] ^ fb;
      end
      return r;
   endfunction

   function automatic logic exp_crc_ok(input logic [47:0] d);
      return CRC_EN && (crc16(d[47:16]) == d[15:0]);
   endfunction

   function automatic logic exp_ferr(input logic [ERR_CNT_W-1:0] e);
      return int'(e) > ERR_THRESH;
   endfunction

   // ---------------------------------------------------------------------------
   // Check and drive helpers (all start and end 1 time unit after a rising edge)
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic accept(input logic [95:0] fr);
      int t;
      t = 0;
      while (bus.in_ready !== 1'b1 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("in_ready_before_accept", 64'(bus.in_ready), 64'(1));
      bus.frame_in = fr;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_frame(input logic [95:0] fr, input int ready_delay,
                            output logic [47:0] d, output logic [ERR_CNT_W-1:0] e,
                            output logic fe, output logic co, output int lat);
      accept(fr);
      wait_valid(lat);
      d  = bus.data_out;
      e  = bus.err_cnt;
      fe = bus.frame_err;
      co = bus.crc_ok;
      repeat (ready_delay) begin
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("out_valid_after_handshake", 64'(bus.out_valid), 64'(0));
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   vec_t                 vecs [7];
   logic [47:0]          d, md, crc_word;
   logic [ERR_CNT_W-1:0] e, me;
   logic                 fe, co, flag;
   logic [95:0]          fr, cw;
   int                   lat;

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.frame_in  = '0;
      bus.out_ready = 1'b0;

      vecs[0] = '{96'h0, 48'h0, 6'd0, 1'b0};
      vecs[1] = '{96'h000003_000003_000001_000003, 48'h8000_0000_0000, 6'd0, 1'b0};
      vecs[2] = '{96'h000003_000003_000001_000002, 48'h8000_0000_0000, 6'd1, 1'b1};
      vecs[3] = '{96'hFFFFFF_FFFFFF_FFFFFF_FFFFFF, 48'hD1A3_468D_1A34, 6'd21, 1'b1};
      vecs[4] = '{encode(48'hFFFF_FFFF_FFFF), 48'hFFFF_FFFF_FFFF, 6'd0, 1'b0};
      vecs[5] = '{encode(48'h1234_5678_9ABC), 48'h1234_5678_9ABC, 6'd0, 1'b0};
      vecs[6] = '{encode(48'h0000_0000_0001), 48'h0000_0000_0001, 6'd0, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  64'(bus.in_ready),  64'(1));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_data",      64'(bus.data_out),  64'(0));
      check("rst_err",       64'(bus.err_cnt),   64'(0));
      check("rst_ferr",      64'(bus.frame_err), 64'(0));
      check("rst_crc_ok",    64'(bus.crc_ok),    64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // All-zero frame with out_ready already high: one-cycle out_valid
      bus.out_ready = 1'b1;
      accept(96'h0);
      wait_valid(lat);
      check("zero_latency", 64'(lat),           64'(48));
      check("zero_data",    64'(bus.data_out),  64'(0));
      check("zero_err",     64'(bus.err_cnt),   64'(0));
      check("zero_ferr",    64'(bus.frame_err), 64'(0));
      @(posedge clk); #1;
      check("zero_one_cycle_valid", 64'(bus.out_valid), 64'(0));
      check("zero_back_idle",       64'(bus.in_ready),  64'(1));
      bus.out_ready = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 7; i++) begin
         run_frame(vecs[i].frame, i % 3, d, e, fe, co, lat);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(48));
         check($sformatf("vec%0d_data", i),    64'(d),   64'(vecs[i].exp_data));
         check($sformatf("vec%0d_err", i),     64'(e),   64'(vecs[i].exp_err));
         check($sformatf("vec%0d_ferr", i),    64'(fe),  64'(vecs[i].exp_ferr));
         check($sformatf("vec%0d_crc_ok", i),  64'(co),  64'(exp_crc_ok(vecs[i].exp_data)));
      end

      // Backpressure: 20 cycles in DONE with a competing in_valid
      accept(vecs[1].frame);
      wait_valid(lat);
      check("bp_latency", 64'(lat), 64'(48));
      d  = bus.data_out;
      e  = bus.err_cnt;
      fe = bus.frame_err;
      check("bp_data", 64'(d), 64'(vecs[1].exp_data));
      bus.frame_in = '1;
      bus.in_valid = 1'b1;
      flag = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.data_out !== d ||
             bus.err_cnt !== e || bus.frame_err !== fe)
            flag = 1'b0;
      end
      check("bp_outputs_stable", 64'(flag), 64'(1));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("bp_release_valid",    64'(bus.out_valid), 64'(0));
      check("bp_release_in_ready", 64'(bus.in_ready),  64'(1));

      // Asynchronous reset at decode cycle 10
      accept(encode(48'hFFFF_FFFF_FFFF));
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready",  64'(bus.in_ready),  64'(1));
      check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("mid_rst_data",      64'(bus.data_out),  64'(0));
      check("mid_rst_err",       64'(bus.err_cnt),   64'(0));
      check("mid_rst_ferr",      64'(bus.frame_err), 64'(0));
      check("mid_rst_crc_ok",    64'(bus.crc_ok),    64'(0));
      #2;
      rst_n = 1'b1;
      flag = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) flag = 1'b1;
      end
      check("mid_rst_no_partial_output", 64'(flag), 64'(0));
      run_frame(vecs[5].frame, 1, d, e, fe, co, lat);
      check("post_rst_latency", 64'(lat), 64'(48));
      check("post_rst_data",    64'(d),   64'(vecs[5].exp_data));
      check("post_rst_err",     64'(e),   64'(0));

      // CRC payload: clean frame, then one corrupted CRC-field pair (P1 of pair 40)
      crc_word = {32'hA5A5_0F0F, crc16(32'hA5A5_0F0F)};
      run_frame(encode(crc_word), 2, d, e, fe, co, lat);
      check("crc_clean_data",   64'(d),  64'(crc_word));
      check("crc_clean_err",    64'(e),  64'(0));
      check("crc_clean_crc_ok", 64'(co), 64'(CRC_EN));
      check("crc_ok_outside_done", 64'(bus.crc_ok), 64'(0));
      cw = encode_cw(crc_word);
      cw[15] = ~cw[15];
      fr = interleave(cw);
      model_decode(fr, md, me);
      run_frame(fr, 0, d, e, fe, co, lat);
      check("crc_bad_data",   64'(d),  64'(md));
      check("crc_bad_err",    64'(e),  64'(me));
      check("crc_bad_ferr",   64'(fe), 64'(exp_ferr(me)));
      check("crc_bad_crc_ok", 64'(co), 64'(0));

      // Randomized frames against the reference model
      for (int i = 0; i < 24; i++) begin
         if (i % 2 == 0) fr = {$urandom, $urandom, $urandom};
         else            fr = encode({16'($urandom), $urandom});
         model_decode(fr, md, me);
         run_frame(fr, int'($urandom_range(0, 3)), d, e, fe, co, lat);
         check($sformatf("rand%0d_latency", i), 64'(lat), 64'(48));
         check($sformatf("rand%0d_data", i),    64'(d),   64'(md));
         check($sformatf("rand%0d_err", i),     64'(e),   64'(me));
         check($sformatf("rand%0d_ferr", i),    64'(fe),  64'(exp_ferr(me)));
         check($sformatf("rand%0d_crc_ok", i),  64'(co),  64'(exp_crc_ok(md)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
